sram_axi_arb: RTL and testbench
===============================

Name: sram_axi_arb

Overview:
- Two-master to one-slave AXI4-Lite arbiter placed in front of the sram slave.
- Shares the SRAM between master 0 (core data port) and master 1 (debug/DMA port).
- Uses round-robin grant.
- Tracks the single outstanding read and steers the read response back to the master that issued it.
- Writes are complete on AW/W handshake; there is no B channel, matching the sram slave.

Parameters:
- AW, 32, address width (matches `MemAddrBus).
- DW, 32, data width (matches `MemBus).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- m0_axi_awaddr / m1_axi_awaddr  input  AW  master write address.
- m0_axi_awvalid / m1_axi_awvalid  input  1  write address valid.
- m0_axi_awready / m1_axi_awready  output  1  write address ready.
- m0_axi_wdata / m1_axi_wdata  input  DW  write data.
- m0_axi_wstrb / m1_axi_wstrb  input  4  byte strobes.
- m0_axi_wvalid / m1_axi_wvalid  input  1  write data valid.
- m0_axi_wready / m1_axi_wready  output  1  write data ready.
- m0_axi_araddr / m1_axi_araddr  input  AW  read address.
- m0_axi_arvalid / m1_axi_arvalid  input  1  read address valid.
- m0_axi_arready / m1_axi_arready  output  1  read address ready.
- m0_axi_rdata / m1_axi_rdata  output  DW  read data.
- m0_axi_rvalid / m1_axi_rvalid  output  1  read data valid.
- m0_axi_rready / m1_axi_rready  input  1  read data ready.
- sram_axi_aw*/w*/ar*/r*  mirrored slave-side set, same widths, opposite directions; connects to sram.

Behaviour:
- Request terms:
  - wreq_i = awvalid_i & wvalid_i. AW alone or W alone is never a request.
  - rreq_i = arvalid_i, masked while state = RD_BUSY.
  - req_i = wreq_i | rreq_i.
- Grant:
  - Combinational, same cycle.
  - Only one master is forwarded per cycle.
  - If both req: grant the master selected by rr_ptr.
  - If one req: grant that master.
- Within the granted master, a write beats a read; the read waits.
- Forwarding: granted master's aw/w/ar signals drive the slave. Slave awready/wready/arready are routed only to the granted master; the non-granted master sees all readies 0.
- rr_ptr update: on any completed slave handshake (write: awvalid&awready; read: arvalid&arready), rr_ptr <= ~granted_idx. Otherwise it holds.
- State machine:
  - IDLE -> RD_BUSY on slave AR handshake; latch rd_owner = granted_idx.
  - RD_BUSY -> IDLE on sram_axi_rvalid & sram_axi_rready.
- Read response routing:
  - In RD_BUSY: mX_rvalid = sram_axi_rvalid for X = rd_owner, else 0.
  - sram_axi_rready = rready of rd_owner.
  - rdata is broadcast to both masters; only the owner's rvalid qualifies it.
- Read latency: sram rvalid rises 1 cycle after AR handshake. Total master-visible latency is 1 cycle plus any arbitration wait.
- In RD_BUSY:
  - Writes from either master are still arbitrated and forwarded.
  - New reads are blocked, including the cycle in which the R handshake completes. The next AR handshake occurs no earlier than the cycle after the R handshake.
- Owner backpressure: rd_owner holds rready=0 -> arbiter stays in RD_BUSY indefinitely. Writes are still served; reads from both masters stall.
- Masters must hold valid and payload until ready, per AXI. The grant may move between masters only while no handshake has occurred, which is legal.
- Reset values (synchronous, rst_n=0 at posedge): state=IDLE, rr_ptr=0 (master 0 favored), rd_owner=0.
- Outputs during reset:
  - All m*_rvalid = 0.
  - sram_axi_rready = 0.
  - Readies follow the combinational grant of IDLE.
- Reset mid-read: the pending response is discarded. The sram slave is reset on the same rst_n.
- Simultaneous m0 write + m1 read: rr_ptr decides. The loser waits at least 1 cycle.

Decomposition:
- Widths come from existing defines.v (`MemAddrBus, `MemBus).
- Add localparams ST_IDLE=1'b0, ST_RD_BUSY=1'b1 locally.
- One natural sub-module: sram_arb_rr, a 2-way round-robin pointer and grant. Inputs req[1:0], hsk, clk, rst_n; output gnt_idx.
- The mux/demux stays in sram_axi_arb.

Test Plan:
- After reset, m0 writes 0xDEADBEEF to 0x10 with wstrb=0xF; m1 then reads 0x10.
  - m0 aw/wready=1 same cycle.
  - m1_arready next cycle.
  - m1_rvalid=1 one cycle later with rdata=0xDEADBEEF.
  - m0_rvalid stays 0.
- Both masters assert write every cycle for 4 cycles. Grants alternate m0, m1, m0, m1 (rr_ptr=0 after reset).
- m0 reads; m0_rready held 0 for 5 cycles; m1 issues a read and a write meanwhile.
  - m1 write accepted during RD_BUSY.
  - m1_arready=0 until the cycle after m0's R handshake.
  - m1 then reads correct data.
- Byte strobe passthrough: m1 writes 0x11223344 with wstrb=0x3 over 0xFFFFFFFF, then reads back 0xFFFF3344.
- m0 has awvalid=1 but wvalid=0 while m1 requests a read. m1 is granted; m0_awready=0 until wvalid rises.
- Assert rst_n=0 while state=RD_BUSY with rvalid pending.
  - Next posedge: all m*_rvalid=0, state IDLE.
  - First post-reset contention is granted to m0.

Source files
------------

// File: rtl/sram_axi_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_axi_arb_pkg : shared widths, FSM encoding and round-robin helper    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package sram_axi_arb_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int NUM_MASTERS = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_BUSY = 1'b1
  } arb_state_e;

  // A lone requester always wins; contention (or silence) defers to the pointer.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    case (req)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ptr;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_axi_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_axi_arb_if : AXI4-Lite subset (AW/W/AR/R, no B) used on all sides   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface sram_axi_arb_if
  import sram_axi_arb_pkg::*;
#(
  parameter int AW = MEM_ADDR_W,
  parameter int DW = MEM_DATA_W
) ();

  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
    input  awready, wready, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
    output awready, wready, arready, rdata, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/sram_arb_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_arb_rr : 2-way round-robin pointer and same-cycle grant index       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sram_arb_rr
  import sram_axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hsk,
  output logic       gnt_idx
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  assign gnt_idx = rr_pick(req, rr_ptr_q);

  // After a served transfer the other master becomes the favoured one.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hsk) begin
      rr_ptr_d = ~gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_axi_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_axi_arb : two-master AXI4-Lite arbiter in front of the sram slave   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sram_axi_arb
  import sram_axi_arb_pkg::*;
#(
  parameter int AW = MEM_ADDR_W,
  parameter int DW = MEM_DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_axi_arb_if.slave  m0,
  sram_axi_arb_if.slave  m1,
  sram_axi_arb_if.master sram
);

  localparam int SW = DW / 8;

  arb_state_e state_q;
  arb_state_e state_d;
  logic       rd_owner_q;
  logic       rd_owner_d;

  logic [1:0]    w_awvalid;
  logic [1:0]    w_wvalid;
  logic [1:0]    w_arvalid;
  logic [1:0]    w_rready;
  logic [AW-1:0] w_awaddr [2];
  logic [AW-1:0] w_araddr [2];
  logic [DW-1:0] w_wdata  [2];
  logic [SW-1:0] w_wstrb  [2];

  logic [1:0] w_wreq;
  logic [1:0] w_rreq;
  logic [1:0] w_req;
  logic [1:0] w_awready;
  logic [1:0] w_wready;
  logic [1:0] w_arready;
  logic [1:0] w_rvalid;

  logic w_busy;
  logic w_gnt_idx;
  logic w_sel_wr;
  logic w_sel_rd;
  logic w_hsk;
  logic w_ar_hsk;
  logic w_r_hsk;

  assign w_awvalid   = {m1.awvalid, m0.awvalid};
  assign w_wvalid    = {m1.wvalid,  m0.wvalid};
  assign w_arvalid   = {m1.arvalid, m0.arvalid};
  assign w_rready    = {m1.rready,  m0.rready};
  assign w_awaddr[0] = m0.awaddr;
  assign w_awaddr[1] = m1.awaddr;
  assign w_araddr[0] = m0.araddr;
  assign w_araddr[1] = m1.araddr;
  assign w_wdata[0]  = m0.wdata;
  assign w_wdata[1]  = m1.wdata;
  assign w_wstrb[0]  = m0.wstrb;
  assign w_wstrb[1]  = m1.wstrb;

  // Busy is qualified by rst_n so reset immediately looks like IDLE on the ports.
  assign w_busy = rst_n & (state_q == ST_RD_BUSY);
  assign w_wreq = w_awvalid & w_wvalid;
  assign w_rreq = w_arvalid & {2{~w_busy}};
  assign w_req  = w_wreq | w_rreq;

  sram_arb_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .hsk     (w_hsk),
    .gnt_idx (w_gnt_idx)
  );

  assign w_sel_wr = w_wreq[w_gnt_idx];
  assign w_sel_rd = w_rreq[w_gnt_idx] & ~w_sel_wr;

  assign sram.awaddr  = w_awaddr[w_gnt_idx];
  assign sram.awvalid = w_sel_wr;
  assign sram.wdata   = w_wdata[w_gnt_idx];
  assign sram.wstrb   = w_wstrb[w_gnt_idx];
  assign sram.wvalid  = w_sel_wr;
  assign sram.araddr  = w_araddr[w_gnt_idx];
  assign sram.arvalid = w_sel_rd;
  assign sram.rready  = w_busy & w_rready[rd_owner_q];

  assign w_ar_hsk = sram.arvalid & sram.arready;
  assign w_r_hsk  = sram.rvalid & sram.rready;
  assign w_hsk    = (sram.awvalid & sram.awready) | w_ar_hsk;

  // Readies reach only the granted master and only for the operation forwarded,
  // so a master holding a lone AW never observes a phantom handshake.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    logic w_sel;
    assign w_sel          = (w_gnt_idx == 1'(gi));
    assign w_awready[gi]  = w_sel & w_sel_wr & sram.awready;
    assign w_wready[gi]   = w_sel & w_sel_wr & sram.wready;
    assign w_arready[gi]  = w_sel & w_sel_rd & sram.arready;
    assign w_rvalid[gi]   = w_busy & (rd_owner_q == 1'(gi)) & sram.rvalid;
  end

  assign m0.awready = w_awready[0];
  assign m0.wready  = w_wready[0];
  assign m0.arready = w_arready[0];
  assign m0.rvalid  = w_rvalid[0];
  assign m0.rdata   = sram.rdata;
  assign m1.awready = w_awready[1];
  assign m1.wready  = w_wready[1];
  assign m1.arready = w_arready[1];
  assign m1.rvalid  = w_rvalid[1];
  assign m1.rdata   = sram.rdata;

  always_comb begin
    state_d    = state_q;
    rd_owner_d = rd_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (w_ar_hsk) begin
          state_d    = ST_RD_BUSY;
          rd_owner_d = w_gnt_idx;
        end
      end
      ST_RD_BUSY: begin
        if (w_r_hsk) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_axi_arb : directed bench with a cycle model of the arbiter       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sram_axi_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_axi_arb_if #(.AW(32), .DW(32)) m0_if ();
  sram_axi_arb_if #(.AW(32), .DW(32)) m1_if ();
  sram_axi_arb_if #(.AW(32), .DW(32)) sram_if ();

  sram_axi_arb #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .sram  (sram_if)
  );

  // Master-side stimulus, indexed by master number.
  logic [1:0]  awv, wv, arv, rr_in;
  logic [31:0] awaddr [2];
  logic [31:0] araddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];

  assign m0_if.awvalid = awv[0];   assign m1_if.awvalid = awv[1];
  assign m0_if.wvalid  = wv[0];    assign m1_if.wvalid  = wv[1];
  assign m0_if.arvalid = arv[0];   assign m1_if.arvalid = arv[1];
  assign m0_if.rready  = rr_in[0]; assign m1_if.rready  = rr_in[1];
  assign m0_if.awaddr  = awaddr[0]; assign m1_if.awaddr = awaddr[1];
  assign m0_if.araddr  = araddr[0]; assign m1_if.araddr = araddr[1];
  assign m0_if.wdata   = wdata[0];  assign m1_if.wdata  = wdata[1];
  assign m0_if.wstrb   = wstrb[0];  assign m1_if.wstrb  = wstrb[1];

  logic [1:0]  awr, wrr, arr, rv;
  logic [31:0] rdata_o [2];
  assign awr = {m1_if.awready, m0_if.awready};
  assign wrr = {m1_if.wready,  m0_if.wready};
  assign arr = {m1_if.arready, m0_if.arready};
  assign rv  = {m1_if.rvalid,  m0_if.rvalid};
  assign rdata_o[0] = m0_if.rdata;
  assign rdata_o[1] = m1_if.rdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Bench sram slave: always write-ready, one read outstanding, data one cycle after AR.
  logic [31:0] s_mem [256];
  logic        s_rvalid = 1'b0;
  logic [31:0] s_rdata  = 32'h0;
  initial for (int i = 0; i < 256; i++) s_mem[i] = 32'h0;

  assign sram_if.awready = 1'b1;
  assign sram_if.wready  = 1'b1;
  assign sram_if.arready = ~s_rvalid;
  assign sram_if.rvalid  = s_rvalid;
  assign sram_if.rdata   = s_rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
    end else begin
      if (sram_if.awvalid && sram_if.wvalid)
        s_mem[sram_if.awaddr[9:2]] <= merge(s_mem[sram_if.awaddr[9:2]], sram_if.wdata, sram_if.wstrb);
      if (sram_if.arvalid && !s_rvalid) begin
        s_rdata  <= s_mem[sram_if.araddr[9:2]];
        s_rvalid <= 1'b1;
      end else if (s_rvalid && sram_if.rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // Reference model: favoured master first, write before read, one read in flight.
  logic [31:0] exp_mem [256];
  initial for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
  logic        mdl_busy = 1'b0, mdl_owner = 1'b0, mdl_ptr = 1'b0;
  logic [31:0] mdl_rd_data = 32'h0;
  logic [1:0]  want_wr, want_rd, e_awr, e_wr, e_arr, e_rv;
  logic        win, win_v, e_fwd_wr, e_fwd_rd, e_rready;

  always @(negedge clk) begin
    want_wr = awv & wv;
    want_rd = (rst_n && mdl_busy) ? 2'b00 : arv;
    if (want_wr[mdl_ptr] || want_rd[mdl_ptr]) begin
      win_v = 1'b1; win = mdl_ptr;
    end else if (want_wr[~mdl_ptr] || want_rd[~mdl_ptr]) begin
      win_v = 1'b1; win = ~mdl_ptr;
    end else begin
      win_v = 1'b0; win = 1'b0;
    end
    e_fwd_wr = win_v && want_wr[win];
    e_fwd_rd = win_v && !want_wr[win] && want_rd[win];
    e_awr = 2'b00; e_wr = 2'b00; e_arr = 2'b00;
    if (e_fwd_wr) begin e_awr[win] = sram_if.awready; e_wr[win] = sram_if.wready; end
    if (e_fwd_rd) e_arr[win] = sram_if.arready;
    for (int i = 0; i < 2; i++)
      e_rv[i] = rst_n && mdl_busy && (mdl_owner == 1'(i)) && sram_if.rvalid;
    e_rready = rst_n && mdl_busy && rr_in[mdl_owner];

    chk("awready", {30'd0, awr}, {30'd0, e_awr});
    chk("wready",  {30'd0, wrr}, {30'd0, e_wr});
    chk("arready", {30'd0, arr}, {30'd0, e_arr});
    chk("rvalid",  {30'd0, rv},  {30'd0, e_rv});
    chk("sram_rready",  {31'd0, sram_if.rready},  {31'd0, e_rready});
    chk("sram_awvalid", {31'd0, sram_if.awvalid}, {31'd0, e_fwd_wr});
    chk("sram_arvalid", {31'd0, sram_if.arvalid}, {31'd0, e_fwd_rd});
    if (e_fwd_wr) begin
      chk("sram_awaddr", sram_if.awaddr, awaddr[win]);
      chk("sram_wdata",  sram_if.wdata,  wdata[win]);
      chk("sram_wstrb",  {28'd0, sram_if.wstrb}, {28'd0, wstrb[win]});
    end
    if (e_fwd_rd) chk("sram_araddr", sram_if.araddr, araddr[win]);
    for (int i = 0; i < 2; i++)
      if (e_rv[i]) chk($sformatf("m%0d_rdata", i), rdata_o[i], mdl_rd_data);

    if (!rst_n) begin
      mdl_busy = 1'b0; mdl_ptr = 1'b0; mdl_owner = 1'b0;
    end else begin
      if (e_fwd_wr && sram_if.awready && sram_if.wready) begin
        exp_mem[awaddr[win][9:2]] = merge(exp_mem[awaddr[win][9:2]], wdata[win], wstrb[win]);
        mdl_ptr = ~win;
      end
      if (e_fwd_rd && sram_if.arready) begin
        mdl_busy = 1'b1; mdl_owner = win; mdl_ptr = ~win;
        mdl_rd_data = exp_mem[araddr[win][9:2]];
      end else if (mdl_busy && sram_if.rvalid && e_rready) begin
        mdl_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic ok;
    awv[m] = 1'b1; wv[m] = 1'b1; awaddr[m] = a; wdata[m] = d; wstrb[m] = s; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); ok = awr[m] & wrr[m];
      tick();
    end
    awv[m] = 1'b0; wv[m] = 1'b0;
    chk($sformatf("m%0d_write_accepted", m), {31'd0, ok}, 32'd1);
  endtask

  task automatic do_read(input int m, input logic [31:0] a, output logic [31:0] d);
    logic ok, got;
    arv[m] = 1'b1; araddr[m] = a; ok = 1'b0; got = 1'b0; d = 32'h0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); ok = arr[m];
      tick();
    end
    arv[m] = 1'b0; rr_in[m] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rv[m]) begin got = 1'b1; d = rdata_o[m]; end
      tick();
    end
    rr_in[m] = 1'b0;
    chk($sformatf("m%0d_read_done", m), {30'd0, ok, got}, 32'd3);
  endtask

  logic [1:0]  g;
  logic [31:0] rd;
  int          k0, k1;

  initial begin
    rst_n = 1'b0;
    awv = '0; wv = '0; arv = '0; rr_in = '0;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; araddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rvalid", {30'd0, rv}, 32'd0);
    chk("rst_sram_rready", {31'd0, sram_if.rready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // m0 write, then m1 reads the same word back
    awv[0] = 1'b1; wv[0] = 1'b1; awaddr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
    @(negedge clk);
    chk("t1_m0_awready", {31'd0, awr[0]}, 32'd1);
    chk("t1_m0_wready",  {31'd0, wrr[0]}, 32'd1);
    tick();
    awv[0] = 1'b0; wv[0] = 1'b0; arv[1] = 1'b1; araddr[1] = 32'h10;
    @(negedge clk);
    chk("t1_m1_arready", {31'd0, arr[1]}, 32'd1);
    tick();
    arv[1] = 1'b0; rr_in[1] = 1'b1;
    @(negedge clk);
    chk("t1_m1_rvalid", {31'd0, rv[1]}, 32'd1);
    chk("t1_m1_rdata", rdata_o[1], 32'hDEADBEEF);
    chk("t1_m0_rvalid", {31'd0, rv[0]}, 32'd0);
    tick();
    rr_in[1] = 1'b0;

    // Both masters write continuously: grants alternate starting at m0
    k0 = 0; k1 = 0;
    awv = 2'b11; wv = 2'b11; wstrb[0] = 4'hF; wstrb[1] = 4'hF;
    for (int c = 0; c < 4; c++) begin
      awaddr[0] = 32'h100 + 32'(4 * k0); wdata[0] = 32'hA000_0000 + 32'(k0);
      awaddr[1] = 32'h200 + 32'(4 * k1); wdata[1] = 32'hB000_0000 + 32'(k1);
      @(negedge clk);
      g = awr;
      chk($sformatf("t2_grant_%0d", c), {30'd0, g}, (c % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      if (g[0]) k0++;
      if (g[1]) k1++;
    end
    awv = 2'b00; wv = 2'b00;

    // m0 read stalled by its own rready while m1 writes and waits to read
    arv[0] = 1'b1; araddr[0] = 32'h10;
    @(negedge clk);
    chk("t3_m0_arready", {31'd0, arr[0]}, 32'd1);
    tick();
    arv[0] = 1'b0;
    arv[1] = 1'b1; araddr[1] = 32'h100;
    awv[1] = 1'b1; wv[1] = 1'b1; awaddr[1] = 32'h300; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF;
    @(negedge clk);
    chk("t3_m1_awready_busy", {31'd0, awr[1]}, 32'd1);
    chk("t3_m1_arready_busy", {31'd0, arr[1]}, 32'd0);
    tick();
    awv[1] = 1'b0; wv[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t3_m1_arready_stall_%0d", c), {31'd0, arr[1]}, 32'd0);
      chk($sformatf("t3_m0_rvalid_hold_%0d", c), {31'd0, rv[0]}, 32'd1);
      tick();
    end
    rr_in[0] = 1'b1;
    @(negedge clk);
    chk("t3_m0_rdata", rdata_o[0], 32'hDEADBEEF);
    chk("t3_m1_arready_rhsk", {31'd0, arr[1]}, 32'd0);
    tick();
    rr_in[0] = 1'b0;
    @(negedge clk);
    chk("t3_m1_arready_after", {31'd0, arr[1]}, 32'd1);
    tick();
    arv[1] = 1'b0; rr_in[1] = 1'b1;
    @(negedge clk);
    chk("t3_m1_rvalid", {31'd0, rv[1]}, 32'd1);
    chk("t3_m1_rdata", rdata_o[1], 32'hA0000000);
    tick();
    rr_in[1] = 1'b0;

    // Byte strobes reach the slave unchanged
    do_write(1, 32'h40, 32'hFFFFFFFF, 4'hF);
    do_write(1, 32'h40, 32'h11223344, 4'h3);
    do_read(1, 32'h40, rd);
    chk("t4_strb_readback", rd, 32'hFFFF3344);

    // AW without W is not a request
    awv[0] = 1'b1; wv[0] = 1'b0; awaddr[0] = 32'h50; wdata[0] = 32'h55; wstrb[0] = 4'hF;
    arv[1] = 1'b1; araddr[1] = 32'h40;
    @(negedge clk);
    chk("t5_m1_arready", {31'd0, arr[1]}, 32'd1);
    chk("t5_m0_awready_nowv", {31'd0, awr[0]}, 32'd0);
    tick();
    arv[1] = 1'b0; rr_in[1] = 1'b1;
    @(negedge clk);
    chk("t5_m0_awready_wait", {31'd0, awr[0]}, 32'd0);
    chk("t5_m1_rdata", rdata_o[1], 32'hFFFF3344);
    tick();
    rr_in[1] = 1'b0; wv[0] = 1'b1;
    @(negedge clk);
    chk("t5_m0_awready_wv", {31'd0, awr[0]}, 32'd1);
    tick();
    awv[0] = 1'b0; wv[0] = 1'b0;

    // Reset with a read response pending, then contend
    arv[0] = 1'b1; araddr[0] = 32'h10;
    @(negedge clk);
    chk("t6_m0_arready", {31'd0, arr[0]}, 32'd1);
    tick();
    arv[0] = 1'b0;
    @(negedge clk);
    chk("t6_m0_rvalid_pending", {31'd0, rv[0]}, 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_in_reset", {30'd0, rv}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rvalid_after_reset", {30'd0, rv}, 32'd0);
    tick();
    awv = 2'b11; wv = 2'b11;
    awaddr[0] = 32'h60; wdata[0] = 32'h6; awaddr[1] = 32'h64; wdata[1] = 32'h7;
    wstrb[0] = 4'hF; wstrb[1] = 4'hF;
    @(negedge clk);
    chk("t6_first_grant_m0", {30'd0, awr}, 32'd1);
    tick();
    awv[0] = 1'b0; wv[0] = 1'b0;
    @(negedge clk);
    chk("t6_second_grant_m1", {30'd0, awr}, 32'd2);
    tick();
    awv = 2'b00; wv = 2'b00;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
